// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad serial transmitter: transmitter state
// encoding, ASCII base codes and the key-code to character mapping.
// Optional build macro: KEYPAD_TX_PARITY_EN adds the PARITY state.
package keypad_pkg;

    // First character of the digit run ('0') and of the letter run ('A').
    localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
    localparam logic [7:0] ASCII_ALPHA_BASE = 8'h41;

    // Transmitter states; PARITY only exists when the parity bit is built in.
`ifdef KEYPAD_TX_PARITY_EN
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;
`endif

    // Key codes 0..9 become '0'..'9', codes 10..15 become 'A'..'F'.
    function automatic logic [7:0] key_to_ascii(input logic [3:0] code);
        logic [7:0] code_ext;
        code_ext = {4'b0000, code};
        if (code < 4'd10) begin
            return ASCII_DIGIT_BASE + code_ext;
        end
        return ASCII_ALPHA_BASE + code_ext - 8'd10;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// Serialiser: start bit, 8 data bits LSB first, optional even-parity bit,
// STOP_BITS stop bits. A byte is accepted through a valid/ready handshake
// while idle or on the final cycle of the last stop bit, so queued bytes
// go out back to back without an idle gap.
// Optional build macro: KEYPAD_TX_PARITY_EN inserts the parity bit.
module uart_tx_core
    import keypad_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int STOP_BITS    = 1
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] load_data,
    output logic       out,
    output logic       busy
);

    localparam int              TW         = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic            STOP_LAST  = 1'(STOP_BITS - 1);

    tx_state_t     state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic          stop_idx_reg, stop_idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic          out_reg, out_next;
`ifdef KEYPAD_TX_PARITY_EN
    logic          parity_reg, parity_next;
`endif

    logic tick;
    logic load_fire;

    // The bit timer reaches its last count on the final cycle of every bit.
    assign tick = (timer_reg == TIMER_LAST);

    // Ready while idle, or exactly when the last stop bit is finishing.
    assign load_ready = (state_reg == TX_IDLE) ||
                        ((state_reg == TX_STOP) && tick && (stop_idx_reg == STOP_LAST));
    assign load_fire  = load_valid && load_ready;

    // Next-state, bit timing and line level for the following cycle.
    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        bit_idx_next  = bit_idx_reg;
        stop_idx_next = stop_idx_reg;
        shift_next    = shift_reg;
        out_next      = out_reg;
`ifdef KEYPAD_TX_PARITY_EN
        parity_next   = parity_reg;
`endif

        if (state_reg != TX_IDLE) begin
            timer_next = tick ? '0 : timer_reg + 1'b1;
        end

        case (state_reg)
            TX_IDLE: begin
                out_next = 1'b1;
            end
            TX_START: begin
                if (tick) begin
                    state_next   = TX_DATA;
                    bit_idx_next = 3'd0;
                    out_next     = shift_reg[0];
                end
            end
            TX_DATA: begin
                if (tick) begin
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef KEYPAD_TX_PARITY_EN
                        state_next = TX_PARITY;
                        out_next   = parity_reg;
`else
                        state_next    = TX_STOP;
                        stop_idx_next = 1'b0;
                        out_next      = 1'b1;
`endif
                    end else begin
                        out_next = shift_reg[1];
                    end
                end
            end
`ifdef KEYPAD_TX_PARITY_EN
            TX_PARITY: begin
                if (tick) begin
                    state_next    = TX_STOP;
                    stop_idx_next = 1'b0;
                    out_next      = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (tick) begin
                    if (stop_idx_reg == STOP_LAST) begin
                        state_next = TX_IDLE;
                        out_next   = 1'b1;
                    end else begin
                        stop_idx_next = stop_idx_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = TX_IDLE;
                out_next   = 1'b1;
            end
        endcase

        // Taking a new byte overrides whatever the state above decided.
        if (load_fire) begin
            state_next  = TX_START;
            timer_next  = '0;
            shift_next  = load_data;
            out_next    = 1'b0;
`ifdef KEYPAD_TX_PARITY_EN
            parity_next = ^load_data;
`endif
        end
    end

    // State register; reset aborts any frame and forces the line idle high.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_reg    <= TX_IDLE;
            timer_reg    <= '0;
            bit_idx_reg  <= 3'd0;
            stop_idx_reg <= 1'b0;
            shift_reg    <= 8'd0;
            out_reg      <= 1'b1;
`ifdef KEYPAD_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            bit_idx_reg  <= bit_idx_next;
            stop_idx_reg <= stop_idx_next;
            shift_reg    <= shift_next;
            out_reg      <= out_next;
`ifdef KEYPAD_TX_PARITY_EN
            parity_reg   <= parity_next;
`endif
        end
    end

    assign out  = out_reg;
    assign busy = (state_reg != TX_IDLE);

endmodule

// File: rtl/keypad_tx_queue.sv
// Keypad-to-serial front end: detects button presses, maps the 4-bit key
// code to an ASCII character, queues characters in a circular FIFO and
// feeds them to the serialiser.
// Optional build macro: KEYPAD_TX_PARITY_EN (passed through to the frame).
module keypad_tx_queue
    import keypad_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DEPTH        = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       btn_deb,
    output logic       out,
    output logic       busy,
    output logic       full,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic                  btn_prev_reg;
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic                  overflow_reg;

    logic                  push_edge;
    logic [7:0]            push_char;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  pop;
    logic                  wr_en;
    logic [DEPTH-1:0][7:0] slot_data;
    logic [7:0]            head_char;
    logic                  core_ready;
    logic                  core_busy;

    // A press is a low-to-high change against the registered level; the key
    // code is captured in that same cycle.
    assign push_edge = btn_deb && !btn_prev_reg;
    assign push_char = key_to_ascii(sw);

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CW'(DEPTH));
    assign pop        = core_ready && !fifo_empty;
    // When full, a press still fits if the head leaves in the same cycle.
    assign wr_en      = push_edge && (!fifo_full || pop);

    // One register per FIFO slot; the head is read combinationally so the
    // serialiser can take it in the cycle it is offered.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [7:0] slot_reg;

        // Store the new character when this slot is the write target.
        always_ff @(posedge sysclk) begin
            if (wr_en && (wr_ptr_reg == AW'(gi))) begin
                slot_reg <= push_char;
            end
        end

        assign slot_data[gi] = slot_reg;
    end

    assign head_char = slot_data[rd_ptr_reg];

    // Edge register, circular pointers, occupancy and sticky overflow.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            btn_prev_reg <= 1'b1;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            btn_prev_reg <= btn_deb;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (wr_en && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !wr_en) begin
                count_reg <= count_reg - 1'b1;
            end
            if (push_edge && !wr_en) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .STOP_BITS    (STOP_BITS)
    ) u_core (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .load_valid (!fifo_empty),
        .load_ready (core_ready),
        .load_data  (head_char),
        .out        (out),
        .busy       (core_busy)
    );

    assign busy     = core_busy || !fifo_empty;
    assign full     = fifo_full;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_keypad_tx_queue.sv
// Scoreboard bench for keypad_tx_queue: characters are predicted when a
// press is driven and compared against frames decoded from the serial line.
// Build with KEYPAD_TX_PARITY_EN defined to exercise the parity bit.
module tb_keypad_tx_queue;

    localparam int CPB       = 4;
    localparam int DEPTH     = 4;
    localparam int STOP_BITS = 1;
`ifdef KEYPAD_TX_PARITY_EN
    localparam int PAR_BITS  = 1;
`else
    localparam int PAR_BITS  = 0;
`endif
    localparam int FRAME_CYC = (1 + 8 + PAR_BITS + STOP_BITS) * CPB;

    logic       sysclk  = 1'b0;
    logic       rst_n   = 1'b0;
    logic [3:0] sw      = 4'd0;
    logic       btn_deb = 1'b0;
    logic       out;
    logic       busy;
    logic       full;
    logic       overflow;

    keypad_tx_queue #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH),
        .STOP_BITS    (STOP_BITS)
    ) dut (
        .sysclk   (sysclk),
        .rst_n    (rst_n),
        .sw       (sw),
        .btn_deb  (btn_deb),
        .out      (out),
        .busy     (busy),
        .full     (full),
        .overflow (overflow)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [7:0] exp_q[$];
    int         start_cyc_q[$];
    int         end_cyc_q[$];
    int         frame_cnt    = 0;
    logic       last_parity  = 1'b0;
    bit         mon_en       = 1'b0;
    bit         abort_flag   = 1'b0;
    string      hex_chars    = "0123456789ABCDEF";

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_char(input logic [3:0] code);
        return hex_chars.getc(int'(code));
    endfunction

    // One press: high for one cycle, then low; sw is scrambled afterwards so
    // a late capture would pick up the wrong code.
    task automatic push_key(input logic [3:0] code, input bit accepted);
        @(negedge sysclk);
        sw      = code;
        btn_deb = 1'b1;
        if (accepted) exp_q.push_back(exp_char(code));
        @(negedge sysclk);
        btn_deb = 1'b0;
        sw      = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frame_cnt < target && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        check_val("frame_wait", frame_cnt, target);
    endtask

    // Line monitor: decodes every frame cycle by cycle and checks it against
    // the scoreboard.
    initial begin : monitor
        logic [7:0] data;
        logic       par;
        int         bad;
        int         s;
        forever begin
            @(negedge sysclk);
            if (mon_en && out === 1'b0) begin
                s    = cyc;
                bad  = 0;
                data = 8'd0;
                par  = 1'b0;
                for (int c = 1; c < CPB; c++) begin
                    @(negedge sysclk);
                    if (out !== 1'b0) bad++;
                end
                for (int b = 0; b < 8; b++) begin
                    @(negedge sysclk);
                    data[b] = out;
                    for (int c = 1; c < CPB; c++) begin
                        @(negedge sysclk);
                        if (out !== data[b]) bad++;
                    end
                end
`ifdef KEYPAD_TX_PARITY_EN
                @(negedge sysclk);
                par = out;
                for (int c = 1; c < CPB; c++) begin
                    @(negedge sysclk);
                    if (out !== par) bad++;
                end
`endif
                for (int k = 0; k < STOP_BITS * CPB; k++) begin
                    @(negedge sysclk);
                    if (out !== 1'b1) bad++;
                end
                if (abort_flag) begin
                    abort_flag = 1'b0;
                    $display("[TB] frame aborted by reset at cycle %0d", s);
                end else begin
                    frame_cnt++;
                    start_cyc_q.push_back(s);
                    end_cyc_q.push_back(cyc);
                    last_parity = par;
                    $display("[TB] frame %0d byte 0x%02h start cycle %0d", frame_cnt, data, s);
                    check_val("scoreboard_has_entry", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check_val("frame_byte", data, exp_q.pop_front());
                    check_val("frame_shape", bad, 0);
`ifdef KEYPAD_TX_PARITY_EN
                    check_val("frame_parity", par, ^data);
`endif
                end
            end
        end
    end

    initial begin : watchdog
        #(100000 * 10);
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int base;
        int idx;
        int low_cnt;

        // Reset values.
        repeat (3) @(negedge sysclk);
        check_val("rst_out", out, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_full", full, 0);
        check_val("rst_overflow", overflow, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge sysclk);

        // Single press of key 7: start two cycles after the edge, busy drops
        // the cycle after the last stop bit.
        @(negedge sysclk);
        sw      = 4'h7;
        btn_deb = 1'b1;
        exp_q.push_back(exp_char(4'h7));
        $display("[TB] push key 0x7");
        @(negedge sysclk);
        btn_deb = 1'b0;
        check_val("line_before_start", out, 1);
        @(negedge sysclk);
        check_val("start_at_edge_plus2", out, 0);
        repeat (FRAME_CYC - 1) @(negedge sysclk);
        check_val("busy_last_stop", busy, 1);
        check_val("out_last_stop", out, 1);
        @(negedge sysclk);
        check_val("busy_after_frame", busy, 0);
        check_val("single_frame_count", frame_cnt, 1);

        // Letter and zero mapping.
        base = frame_cnt;
        push_key(4'hC, 1'b1);
        $display("[TB] push key 0xC");
        wait_frames(base + 1, FRAME_CYC + 20);
        push_key(4'h0, 1'b1);
        $display("[TB] push key 0x0");
        wait_frames(base + 2, FRAME_CYC + 20);
        repeat (5) @(negedge sysclk);

        // Burst of six presses during the first frame: one in flight, four
        // queued, one dropped; five frames back to back.
        base = frame_cnt;
        idx  = end_cyc_q.size();
        for (int k = 1; k <= 6; k++) begin
            push_key(4'(k), k <= 5);
            $display("[TB] push key 0x%0h%s", k, (k <= 5) ? "" : " (expect drop)");
        end
        @(negedge sysclk);
        check_val("burst_overflow", overflow, 1);
        check_val("burst_full", full, 1);
        wait_frames(base + 5, 5 * FRAME_CYC + 100);
        if (end_cyc_q.size() >= idx + 5)
            check_val("burst_span", end_cyc_q[idx + 4] - start_cyc_q[idx] + 1, 5 * FRAME_CYC);
        repeat (60) @(negedge sysclk);
        check_val("burst_frames", frame_cnt, base + 5);
        check_val("burst_queue_drained", exp_q.size(), 0);
        check_val("burst_busy_idle", busy, 0);
        check_val("overflow_sticky", overflow, 1);

        // Button held for 1000 cycles sends exactly one frame.
        base = frame_cnt;
        @(negedge sysclk);
        sw      = 4'h9;
        btn_deb = 1'b1;
        exp_q.push_back(exp_char(4'h9));
        $display("[TB] hold key 0x9 for 1000 cycles");
        repeat (1000) @(negedge sysclk);
        btn_deb = 1'b0;
        repeat (2 * FRAME_CYC) @(negedge sysclk);
        check_val("held_button_frames", frame_cnt, base + 1);

        // Reset mid-DATA with more characters queued and the button held
        // through reset.
        base = frame_cnt;
        push_key(4'hA, 1'b1);
        push_key(4'hB, 1'b1);
        push_key(4'hD, 1'b1);
        $display("[TB] push keys 0xA 0xB 0xD, then reset mid-frame");
        repeat (8) @(negedge sysclk);
        abort_flag = 1'b1;
        rst_n      = 1'b0;
        btn_deb    = 1'b1;
        sw         = 4'h5;
        @(negedge sysclk);
        rst_n = 1'b1;
        check_val("midframe_rst_out", out, 1);
        check_val("midframe_rst_busy", busy, 0);
        check_val("midframe_rst_full", full, 0);
        check_val("midframe_rst_overflow", overflow, 0);
        exp_q.delete();
        low_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge sysclk);
            if (out !== 1'b1) low_cnt++;
        end
        btn_deb = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge sysclk);
            if (out !== 1'b1) low_cnt++;
        end
        check_val("post_reset_line_quiet", low_cnt, 0);
        check_val("post_reset_frames", frame_cnt, base);
        check_val("post_reset_busy", busy, 0);

        // Recovery after reset.
        push_key(4'hE, 1'b1);
        $display("[TB] push key 0xE after reset");
        wait_frames(base + 1, FRAME_CYC + 20);

`ifdef KEYPAD_TX_PARITY_EN
        // Even parity: '3' has four ones, '1' has three.
        push_key(4'h3, 1'b1);
        $display("[TB] push key 0x3 (parity)");
        wait_frames(base + 2, FRAME_CYC + 20);
        check_val("parity_0x33", last_parity, 0);
        push_key(4'h1, 1'b1);
        $display("[TB] push key 0x1 (parity)");
        wait_frames(base + 3, FRAME_CYC + 20);
        check_val("parity_0x31", last_parity, 1);
`endif

        repeat (10) @(negedge sysclk);
        check_val("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/keypad_tx_queue.md
KEYPAD_TX_QUEUE -- requirements
Module: keypad_tx_queue

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, sysclk cycles per serial bit (legal range 4..65535).
REQ-002 SHALL have parameter DEPTH, default 8, character FIFO entries (power of two, 2..64).
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-004 SHALL have port sysclk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port sw  in  4  key code selecting the character.
REQ-007 SHALL have port btn_deb  in  1  debounced push level, synchronous to sysclk.
REQ-008 SHALL have port out  out  1  serial line, idle high.
REQ-009 SHALL have port busy  out  1  high while a frame is on the line or the FIFO is non-empty.
REQ-010 SHALL have port full  out  1  FIFO holds DEPTH entries.
REQ-011 SHALL have port overflow  out  1  sticky: a push was dropped.

Function
REQ-012 SHALL map sw to ASCII: 0..9 -> 0x30..0x39, 10..15 -> 0x41..0x46 ('A'..'F'); every code is valid.
REQ-013 SHALL enqueue exactly one character per btn_deb rising edge (registered previous level low, current high); a held button enqueues nothing further.
REQ-014 SHALL capture sw in the same cycle the edge is detected.
REQ-015 SHALL drop the character on an edge while full=1, leave FIFO contents unchanged, and set overflow.
REQ-016 SHALL use a circular FIFO whose pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits wide, and full is count==DEPTH.
REQ-017 SHALL, on a simultaneous enqueue and dequeue while full, accept both (count unchanged, no overflow).
REQ-018 SHALL implement the transmitter FSM IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
REQ-019 SHALL, in IDLE with FIFO non-empty, pop the head entry and enter START in the next cycle.
REQ-020 SHALL hold each bit for exactly CLKS_PER_BIT cycles, using a bit timer counting 0..CLKS_PER_BIT-1.
REQ-021 SHALL drive START as 0, then 8 data bits LSB first, then STOP_BITS stop bits at 1.
REQ-022 SHALL, from STOP, go directly to START when the FIFO is non-empty (back-to-back frames, no idle gap).
REQ-023 SHALL drive out low exactly 2 cycles after the edge-detect cycle when the transmitter is idle and the FIFO empty.
REQ-024 SHALL drop busy to 0 in the cycle after the last stop bit completes with the FIFO empty.

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge, set out=1, busy=0, full=0, overflow=0, FSM=IDLE, pointers/count/timers=0, and the edge register=1 so a button held through reset does not enqueue.
REQ-026 SHALL abort a frame in progress on reset mid-frame: out returns to 1 on the next edge and queued characters are discarded.

Configuration
REQ-027 SHALL, when macro KEYPAD_TX_PARITY_EN is defined, insert one even-parity bit (XOR of the 8 data bits) in state PARITY between DATA and STOP.
REQ-028 SHALL, without KEYPAD_TX_PARITY_EN, have no PARITY state, use 8N1/8N2 framing, and contain no parity logic.

Structure
REQ-029 SHALL place the FSM state enum and the ASCII base constants (0x30, 0x41) in shared package keypad_pkg.
REQ-030 SHALL implement the serialiser (FSM, bit timer, shift register) as sub-module uart_tx_core with a valid/ready load handshake; the top level holds the edge detect, mapping and FIFO.

Verification
REQ-031 SHALL verify: CLKS_PER_BIT=4, sw=4'h7, one push -> out=0 at edge+2, bits 1,1,1,0,1,1,0,0 (0x37) at 4 cycles each, then stop 1, busy=0 afterwards.
REQ-032 SHALL verify: sw=4'hC push -> byte 0x43 on the line; sw=4'h0 push -> byte 0x30.
REQ-033 SHALL verify: DEPTH=4, 6 pushes during the first frame -> the first pops immediately, 4 are queued, 1 is dropped, overflow=1, exactly 5 back-to-back frames with no idle gap.
REQ-034 SHALL verify: btn_deb held high for 1000 cycles -> exactly one frame sent.
REQ-035 SHALL verify: rst_n low for 1 cycle mid-DATA -> out=1 on the next cycle, busy=0, no further frames; btn held through reset -> no enqueue.
REQ-036 SHALL verify: with KEYPAD_TX_PARITY_EN defined, sw=4'h3 (0x33, four ones) -> parity bit 0, then stop bit; sw=4'h1 (0x31, three ones) -> parity bit 1.
